// File: rtl/core_ex_muldiv.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, IDLE/CALC/DONE handshake.
// Define CORE_MULDIV_SINGLE_CYCLE_MUL_EN to compute multiplies with a combinational product in one step.
module core_ex_muldiv #(
    parameter int unsigned XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_rs1_dout,
    input  logic [XLEN-1:0] i_rs2_dout,
    input  logic [4:0]      i_rd,
    input  logic            i_flush,
    input  logic            i_ready,
    output logic            o_valid,
    output logic [XLEN-1:0] o_result,
    output logic [4:0]      o_rd,
    output logic            o_busy
);
    localparam int unsigned CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            div_q, rem_q, mhi_q, neg_q, fast_q;
    logic [XLEN-1:0] hi_q, lo_q, b_q;

    logic            sgn1, sgn2, neg1, neg2, neg_acc, fast;
    logic [XLEN-1:0] mag1, mag2, fast_res;

`ifdef CORE_MULDIV_SINGLE_CYCLE_MUL_EN
    logic [2*XLEN-1:0] pm, pm_fix;
    always_comb begin
        pm     = {{XLEN{1'b0}}, mag1} * {{XLEN{1'b0}}, mag2};
        pm_fix = (neg1 ^ neg2) ? -pm : pm;
    end
`endif

    // Operand decode at acceptance: magnitudes, result sign, and the one-step cases.
    always_comb begin
        sgn1     = i_funct3[2] ? !i_funct3[0] : (i_funct3[1:0] != 2'b11);
        sgn2     = i_funct3[2] ? !i_funct3[0] : !i_funct3[1];
        neg1     = sgn1 & i_rs1_dout[XLEN-1];
        neg2     = sgn2 & i_rs2_dout[XLEN-1];
        mag1     = neg1 ? -i_rs1_dout : i_rs1_dout;
        mag2     = neg2 ? -i_rs2_dout : i_rs2_dout;
        neg_acc  = (i_funct3[2] & i_funct3[1]) ? neg1 : (neg1 ^ neg2);
        fast     = 1'b0;
        fast_res = '0;
        if (i_funct3[2]) begin
            if (i_rs2_dout == '0) begin
                fast     = 1'b1;
                fast_res = i_funct3[1] ? i_rs1_dout : '1;
            end else if (sgn1 && (i_rs1_dout == {1'b1, {(XLEN-1){1'b0}}}) && (i_rs2_dout == '1)) begin
                fast     = 1'b1;
                fast_res = i_funct3[1] ? '0 : i_rs1_dout;
            end
        end
`ifdef CORE_MULDIV_SINGLE_CYCLE_MUL_EN
        else begin
            fast     = 1'b1;
            fast_res = (i_funct3[1:0] == 2'b00) ? pm_fix[XLEN-1:0] : pm_fix[2*XLEN-1:XLEN];
        end
`endif
    end

    logic [XLEN:0]     sum, rsh, diff;
    logic [XLEN-1:0]   hi_n, lo_n, dsel, fin;
    logic [2*XLEN-1:0] pfix;

    // hi/lo hold {partial product, multiplier} for multiply and {remainder, quotient} for divide.
    always_comb begin
        sum  = {1'b0, hi_q} + ({1'b0, b_q} & {(XLEN+1){lo_q[0]}});
        rsh  = {hi_q, lo_q[XLEN-1]};
        diff = rsh - {1'b0, b_q};
        if (div_q) begin
            hi_n = diff[XLEN] ? rsh[XLEN-1:0] : diff[XLEN-1:0];
            lo_n = {lo_q[XLEN-2:0], !diff[XLEN]};
        end else begin
            hi_n = sum[XLEN:1];
            lo_n = {sum[0], lo_q[XLEN-1:1]};
        end
        pfix = neg_q ? -{hi_n, lo_n} : {hi_n, lo_n};
        dsel = rem_q ? hi_n : lo_n;
        if (div_q) fin = neg_q ? -dsel : dsel;
        else       fin = mhi_q ? pfix[2*XLEN-1:XLEN] : pfix[XLEN-1:0];
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            div_q    <= 1'b0;
            rem_q    <= 1'b0;
            mhi_q    <= 1'b0;
            neg_q    <= 1'b0;
            fast_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            o_valid  <= 1'b0;
            o_ready  <= 1'b1;
            o_busy   <= 1'b0;
            o_result <= '0;
            o_rd     <= '0;
        end else if (i_flush) begin
            state    <= IDLE;
            o_valid  <= 1'b0;
            o_ready  <= 1'b1;
            o_busy   <= 1'b0;
            o_result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        state   <= CALC;
                        cnt     <= '0;
                        div_q   <= i_funct3[2];
                        rem_q   <= i_funct3[1];
                        mhi_q   <= (i_funct3[1:0] != 2'b00);
                        neg_q   <= neg_acc;
                        fast_q  <= fast;
                        hi_q    <= '0;
                        lo_q    <= fast ? fast_res : mag1;
                        b_q     <= mag2;
                        o_rd    <= i_rd;
                        o_ready <= 1'b0;
                        o_busy  <= 1'b1;
                    end
                end
                CALC: begin
                    if (fast_q) begin
                        state    <= DONE;
                        o_valid  <= 1'b1;
                        o_result <= lo_q;
                    end else begin
                        hi_q <= hi_n;
                        lo_q <= lo_n;
                        cnt  <= cnt + 1'b1;
                        if (cnt == CW'(XLEN-1)) begin
                            state    <= DONE;
                            o_valid  <= 1'b1;
                            o_result <= fin;
                        end
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        state    <= IDLE;
                        o_valid  <= 1'b0;
                        o_ready  <= 1'b1;
                        o_busy   <= 1'b0;
                        o_result <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_core_ex_muldiv.sv
// Self-checking bench for core_ex_muldiv (XLEN=32): directed corner cases plus random ops
// against a plain-arithmetic reference model.
module tb_core_ex_muldiv;
    localparam int unsigned XLEN = 32;
`ifdef CORE_MULDIV_SINGLE_CYCLE_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 32;
`endif

    logic            i_clk = 1'b0;
    logic            i_rst_n = 1'b0;
    logic            i_valid = 1'b0;
    logic            o_ready;
    logic [2:0]      i_funct3 = '0;
    logic [XLEN-1:0] i_rs1_dout = '0;
    logic [XLEN-1:0] i_rs2_dout = '0;
    logic [4:0]      i_rd = '0;
    logic            i_flush = 1'b0;
    logic            i_ready = 1'b0;
    logic            o_valid;
    logic [XLEN-1:0] o_result;
    logic [4:0]      o_rd;
    logic            o_busy;

    int tests = 0;
    int fails = 0;

    core_ex_muldiv #(.XLEN(XLEN)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_funct3(i_funct3), .i_rs1_dout(i_rs1_dout), .i_rs2_dout(i_rs2_dout), .i_rd(i_rd),
        .i_flush(i_flush), .i_ready(i_ready), .o_valid(o_valid), .o_result(o_result),
        .o_rd(o_rd), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint            sa, sb, ubs;
        longint unsigned   ua, ub;
        logic [63:0]       p;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        ubs = longint'(ub);
        case (f)
            3'd0: begin p = ua * ub;  return p[31:0];  end
            3'd1: begin p = sa * sb;  return p[63:32]; end
            3'd2: begin p = sa * ubs; return p[63:32]; end
            3'd3: begin p = ua * ub;  return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = sa / sb;
                return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                p = sa % sb;
                return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (!f[2]) return MUL_LAT;
        if (b == 0) return 1;
        if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 32;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        @(negedge i_clk);
        chk("ready_before_issue", 32'(o_ready), 32'd1);
        i_valid = 1'b1; i_funct3 = f; i_rs1_dout = a; i_rs2_dout = b; i_rd = rd; i_ready = 1'b0;
        @(posedge i_clk); #1;
        i_valid = 1'b0; i_rs1_dout = $urandom; i_rs2_dout = $urandom; i_rd = 5'($urandom);
        chk("busy_after_accept", 32'(o_busy), 32'd1);
    endtask

    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input int el, input logic [4:0] rd, input int hold);
        int n;
        start_op(f, a, b, rd);
        n = 0;
        while (o_valid !== 1'b1 && n < 100) begin
            @(posedge i_clk); #1;
            n++;
        end
        chk($sformatf("latency f%0d a=%h b=%h", f, a, b), 32'(n), 32'(el));
        chk($sformatf("result f%0d a=%h b=%h", f, a, b), o_result, er);
        chk("rd", 32'(o_rd), 32'(rd));
        for (int i = 0; i < hold; i++) begin
            @(posedge i_clk); #1;
            chk("hold_valid", 32'(o_valid), 32'd1);
            chk("hold_result", o_result, er);
            chk("hold_rd", 32'(o_rd), 32'(rd));
            chk("hold_not_ready", 32'(o_ready), 32'd0);
        end
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_ready = 1'b0;
        chk("retire_valid", 32'(o_valid), 32'd0);
        chk("retire_ready", 32'(o_ready), 32'd1);
        chk("retire_busy", 32'(o_busy), 32'd0);
        chk("retire_result_zero", o_result, 32'd0);
    endtask

    task automatic watch_no_valid(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge i_clk); #1;
            if (o_valid !== 1'b0) seen++;
        end
        chk(tag, 32'(seen), 32'd0);
    endtask

    initial begin
        logic [2:0]  f;
        logic [31:0] a, b;

        // reset with a request present: reset must win over acceptance
        i_rst_n = 1'b0; i_valid = 1'b1; i_rs2_dout = 32'd3;
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_result", o_result, 32'd0);
        chk("rst_rd", 32'(o_rd), 32'd0);
        i_valid = 1'b0; i_rst_n = 1'b1;

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT, 5'd3, 0);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT, 5'd4, 0);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT, 5'd5, 0);
        run_op(3'd5, 32'd100, 32'd0, 32'hFFFF_FFFF, 1, 5'd6, 0);
        run_op(3'd7, 32'd100, 32'd0, 32'd100, 1, 5'd7, 0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 5'd8, 0);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 5'd9, 0);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32, 5'd10, 0);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32, 5'd11, 0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, 5'd12, 0);

        // result held in DONE while writeback stalls
        run_op(3'd4, 32'd1000, 32'hFFFF_FFF9, 32'hFFFF_FF72, 32, 5'd21, 5);

        // flush at iteration 10 of a divide
        start_op(3'd4, 32'd12345, 32'd67, 5'd13);
        repeat (9) @(posedge i_clk);
        @(negedge i_clk);
        i_flush = 1'b1;
        @(posedge i_clk); #1;
        i_flush = 1'b0;
        chk("flush_ready", 32'(o_ready), 32'd1);
        chk("flush_busy", 32'(o_busy), 32'd0);
        chk("flush_valid", 32'(o_valid), 32'd0);
        watch_no_valid("no_valid_after_flush", 40);

        // flush coincident with a request in IDLE blocks acceptance
        @(negedge i_clk);
        i_valid = 1'b1; i_flush = 1'b1; i_funct3 = 3'd0; i_rs1_dout = 32'd2; i_rs2_dout = 32'd3;
        @(posedge i_clk); #1;
        i_valid = 1'b0; i_flush = 1'b0;
        chk("flush_blocks_ready", 32'(o_ready), 32'd1);
        chk("flush_blocks_busy", 32'(o_busy), 32'd0);
        watch_no_valid("no_valid_after_blocked", 40);
        run_op(3'd4, 32'd12345, 32'd67, 32'd184, 32, 5'd14, 0);

        // reset in the middle of CALC
        start_op(3'd5, 32'd999, 32'd10, 5'd15);
        repeat (5) @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b0;
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        chk("midrst_valid", 32'(o_valid), 32'd0);
        chk("midrst_ready", 32'(o_ready), 32'd1);
        chk("midrst_busy", 32'(o_busy), 32'd0);
        chk("midrst_result", o_result, 32'd0);
        chk("midrst_rd", 32'(o_rd), 32'd0);
        watch_no_valid("no_valid_after_reset", 40);
        run_op(3'd7, 32'd999, 32'd10, 32'd9, 32, 5'd16, 0);

        for (int t = 0; t < 40; t++) begin
            f = 3'($urandom_range(0, 7));
            a = pick();
            b = pick();
            run_op(f, a, b, model(f, a, b), exp_lat(f, a, b), 5'($urandom), $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/core_ex_muldiv.md
CORE_EX_MULDIV -- requirements
Module: core_ex_muldiv

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning the operand and result width in bits (even, >=8).
REQ-002 SHALL have i_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have i_rst_n, input, 1, reset: synchronous, active-low.
REQ-004 SHALL have i_valid, input, 1, meaning an operation is presented by the issue side.
REQ-005 SHALL have o_ready, output, 1, meaning the block can accept an operation.
REQ-006 SHALL have i_funct3, input, 3, the RV32M op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SHALL have i_rs1_dout and i_rs2_dout, input, XLEN each, the already-forwarded operands.
REQ-008 SHALL have i_rd, input, 5, the destination register tag.
REQ-009 SHALL have i_flush, input, 1, a pipeline kill that discards any in-flight operation.
REQ-010 SHALL have i_ready, input, 1, meaning the writeback side accepts the result.
REQ-011 SHALL have o_valid, output, 1, meaning o_result and o_rd are valid.
REQ-012 SHALL have o_result, output, XLEN, the operation result.
REQ-013 SHALL have o_rd, output, 5, the tag captured at acceptance.
REQ-014 SHALL have o_busy, output, 1, the stall request to hazard control, high in every state other than IDLE.

Function
REQ-015 SHALL implement the states IDLE, CALC and DONE; o_ready SHALL be high only in IDLE.
REQ-016 Acceptance SHALL be i_valid & o_ready & !i_flush at a rising edge k; operands, funct3 and rd SHALL be latched at edge k.
REQ-017 From IDLE, acceptance SHALL go to CALC with the iteration counter at 0; without acceptance the block SHALL stay in IDLE.
REQ-018 CALC SHALL perform one shift-add (multiply) or one restoring-subtract (divide) step per cycle, on magnitudes with the signs fixed up at completion.
REQ-019 After XLEN iterations the block SHALL enter DONE at edge k+XLEN, so o_valid is first high in the cycle after edge k+XLEN.
REQ-020 When the divisor is 0 at acceptance, the block SHALL enter DONE at edge k+1, with quotient all-ones (DIV, DIVU) and remainder equal to the dividend (REM, REMU).
REQ-021 For signed overflow (dividend = most negative, divisor = -1), the block SHALL enter DONE at edge k+1, with DIV giving the most negative value and REM giving 0.
REQ-022 MUL SHALL return the low XLEN bits of the 2*XLEN product; MULH, MULHSU and MULHU SHALL return the high XLEN bits with signed*signed, signed*unsigned and unsigned*unsigned operands respectively.
REQ-023 The signed quotient SHALL round toward zero, and the remainder SHALL take the sign of the dividend.
REQ-024 In DONE, o_valid SHALL stay high and o_result/o_rd SHALL stay stable until i_ready is high at an edge; that edge SHALL return the block to IDLE.
REQ-025 No new operation SHALL be accepted in the same cycle that DONE retires; back-to-back throughput SHALL be one operation per (latency+1) cycles minimum.
REQ-026 i_flush high at any edge SHALL force IDLE, drop o_valid in the next cycle and discard the result.
REQ-027 i_flush coincident with i_valid in IDLE SHALL block acceptance.
REQ-028 When o_valid is low, o_result SHALL be 0.

Reset
REQ-029 When i_rst_n is low at an edge, the state SHALL become IDLE, the counter 0 and all datapath registers 0.
REQ-030 During reset, outputs SHALL be o_valid=0, o_ready=1, o_busy=0, o_result=0 and o_rd=0.
REQ-031 Reset SHALL take precedence over i_flush and over acceptance.
REQ-032 Reset mid-CALC or in DONE SHALL abandon the operation with no o_valid pulse.

Configuration
REQ-033 With macro CORE_MULDIV_SINGLE_CYCLE_MUL_EN defined, the four multiply ops SHALL use a combinational 2*XLEN product and enter DONE at edge k+1; division SHALL be unchanged.
REQ-034 Without CORE_MULDIV_SINGLE_CYCLE_MUL_EN, multiplies SHALL be iterative as in REQ-019, and no full-width multiplier SHALL be instantiated.

Verification (XLEN=32)
REQ-035 SHALL cover MUL 7 * 0xFFFFFFFD -> o_result 0xFFFFFFEB, o_valid first high the cycle after edge k+32 (k+1 with macro).
REQ-036 SHALL cover MULH 0x80000000 * 0x80000000 -> 0x40000000, and MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-037 SHALL cover DIVU 100 / 0 -> 0xFFFFFFFF and REMU 100 / 0 -> 100, plus DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM -> 0, each with o_valid the cycle after edge k+1.
REQ-038 SHALL cover DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD and REM -> 0xFFFFFFFF, with latency 32.
REQ-039 SHALL cover a result held in DONE with i_ready low for 5 cycles -> o_valid, o_result and o_rd stable throughout, and IDLE the edge after i_ready rises.
REQ-040 SHALL cover i_flush at iteration 10 of a DIV, and i_rst_n low mid-CALC -> IDLE next edge, no o_valid pulse, then a new op accepted and its correct result produced.
